// File: rtl/pcm_sample_fifo_if.sv
// Sample stream handshake carried from the PCM FIFO head to its consumer.
// The FIFO drives the master side; the consumer drives out_ready.
interface pcm_sample_fifo_if;
   logic signed [15:0] out_data;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/pcm_sample_fifo.sv
// Brings decimated PCM samples from the pdm_clk domain into clk, optionally
// removes DC with a first-order high-pass, and buffers them in a FWFT FIFO.
module pcm_sample_fifo #(
   parameter int DEPTH    = 16,
   parameter int DC_SHIFT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pcm_clk,
   input  logic signed [15:0]     pcm,
   pcm_sample_fifo_if.master      out,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   input  logic                   clear_overflow
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic               sync1_reg;
   logic               sync2_reg;
   logic               sync3_reg;
   logic               edge_pulse;
   logic signed [15:0] x_reg;
   logic               cap_vld_reg;
   logic signed [15:0] y_next;
   logic signed [15:0] y_reg;
   logic               y_vld_reg;

   // Only the strobe is synchronized; pcm is held stable long enough to be
   // sampled directly once the synchronized edge is seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         sync3_reg <= 1'b0;
      end else begin
         sync1_reg <= pcm_clk;
         sync2_reg <= sync1_reg;
         sync3_reg <= sync2_reg;
      end
   end

   assign edge_pulse = sync2_reg & ~sync3_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_reg       <= '0;
         cap_vld_reg <= 1'b0;
      end else begin
         cap_vld_reg <= edge_pulse;
         if (edge_pulse) begin
            x_reg <= pcm;
         end
      end
   end

   generate
      if (DC_SHIFT == 0) begin : g_bypass
         assign y_next = x_reg;
      end else begin : g_dc
         logic signed [39:0] acc_reg;
         logic signed [39:0] acc_next;
         logic signed [39:0] diff_ext;
         logic signed [39:0] acc_decay;
         logic signed [15:0] x_prev_reg;
         logic signed [16:0] diff;
         logic signed [31:0] y_wide;

         // acc carries 8 fractional bits; it is left to grow unclamped so the
         // pole stays exact, and only the presented sample saturates.
         always_comb begin
            diff      = {x_reg[15], x_reg} - {x_prev_reg[15], x_prev_reg};
            diff_ext  = {{23{diff[16]}}, diff};
            acc_decay = acc_reg >>> DC_SHIFT;
            acc_next  = acc_reg + (diff_ext <<< 8) - acc_decay;
            y_wide    = 32'(acc_next >>> 8);
            if (y_wide > 32'sd32767) begin
               y_next = 16'sh7FFF;
            end else if (y_wide < -32'sd32768) begin
               y_next = 16'sh8000;
            end else begin
               y_next = y_wide[15:0];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               acc_reg    <= '0;
               x_prev_reg <= '0;
            end else if (cap_vld_reg) begin
               acc_reg    <= acc_next;
               x_prev_reg <= x_reg;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_reg     <= '0;
         y_vld_reg <= 1'b0;
      end else begin
         y_vld_reg <= cap_vld_reg;
         if (cap_vld_reg) begin
            y_reg <= y_next;
         end
      end
   end

   logic signed [15:0] mem [DEPTH];
   logic [AW:0]        wptr_reg;
   logic [AW:0]        rptr_reg;
   logic [AW:0]        wptr_next;
   logic [AW:0]        rptr_next;
   logic [AW:0]        level_reg;
   logic signed [15:0] out_data_reg;
   logic               out_valid_reg;
   logic               overflow_reg;
   logic               full;
   logic               rd_en;
   logic               wr_en;
   logic               drop;

   assign full  = (wptr_reg[AW] != rptr_reg[AW]) &&
                  (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
   assign rd_en = out_valid_reg & out.out_ready;
   // A read in the same cycle frees the slot a full FIFO needs.
   assign wr_en = y_vld_reg & (~full | rd_en);
   assign drop  = y_vld_reg & full & ~rd_en;

   always_comb begin
      rptr_next = rptr_reg;
      wptr_next = wptr_reg;
      if (rd_en) begin
         rptr_next = rptr_reg + PTR_ONE;
      end
      if (wr_en) begin
         wptr_next = wptr_reg + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wptr_reg[AW-1:0]] <= y_reg;
      end
   end

   // The head register is loaded from the incoming sample when it becomes
   // the head directly, otherwise from the buffer after a pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_reg      <= '0;
         rptr_reg      <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         wptr_reg      <= wptr_next;
         rptr_reg      <= rptr_next;
         out_valid_reg <= (wptr_next != rptr_next);
         if (wr_en && (wptr_reg == rptr_next)) begin
            out_data_reg <= y_reg;
         end else if (rd_en) begin
            out_data_reg <= mem[rptr_next[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         case ({wr_en, rd_en})
            2'b10:   level_reg <= level_reg + PTR_ONE;
            2'b01:   level_reg <= level_reg - PTR_ONE;
            default: level_reg <= level_reg;
         endcase
         if (drop) begin
            overflow_reg <= 1'b1;
         end else if (clear_overflow) begin
            overflow_reg <= 1'b0;
         end
      end
   end

   assign out.out_data  = out_data_reg;
   assign out.out_valid = out_valid_reg;
   assign level         = level_reg;
   assign overflow      = overflow_reg;

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Directed bench: a bypass instance (DEPTH=4) and a DC-blocking instance
// (DEPTH=16, DC_SHIFT=4), each with its own strobe, sample and reset.
module tb_pcm_sample_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic        byp_rst_n;
   logic        byp_pcm_clk;
   logic [15:0] byp_pcm;
   logic        byp_clear;
   logic [2:0]  byp_level;
   logic        byp_ovf;
   pcm_sample_fifo_if byp_if ();

   logic        dc_rst_n;
   logic        dc_pcm_clk;
   logic [15:0] dc_pcm;
   logic        dc_clear;
   logic [4:0]  dc_level;
   logic        dc_ovf;
   pcm_sample_fifo_if dc_if ();

   pcm_sample_fifo #(.DEPTH(4), .DC_SHIFT(0)) u_byp (
      .clk            (clk),
      .rst_n          (byp_rst_n),
      .pcm_clk        (byp_pcm_clk),
      .pcm            (byp_pcm),
      .out            (byp_if),
      .level          (byp_level),
      .overflow       (byp_ovf),
      .clear_overflow (byp_clear)
   );

   pcm_sample_fifo #(.DEPTH(16), .DC_SHIFT(4)) u_dc (
      .clk            (clk),
      .rst_n          (dc_rst_n),
      .pcm_clk        (dc_pcm_clk),
      .pcm            (dc_pcm),
      .out            (dc_if),
      .level          (dc_level),
      .overflow       (dc_ovf),
      .clear_overflow (dc_clear)
   );

   logic [15:0] mon_q [$];
   bit          mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en && byp_if.out_valid && byp_if.out_ready) begin
         mon_q.push_back(byp_if.out_data);
      end
   end

   // mode 1 pulses clear_overflow, mode 2 pulses out_ready, in the write cycle
   task automatic send_byp(input logic [15:0] v, input int mode);
      @(negedge clk);
      byp_pcm     = v;
      byp_pcm_clk = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (mode == 1) byp_clear = (k == 4);
         if (mode == 2) byp_if.out_ready = (k == 4);
      end
      byp_pcm_clk = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_dc(input logic [15:0] v);
      @(negedge clk);
      dc_pcm     = v;
      dc_pcm_clk = 1'b1;
      repeat (10) @(negedge clk);
      dc_pcm_clk = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic reset_byp;
      @(negedge clk);
      byp_rst_n = 1'b0;
      repeat (2) @(negedge clk);
      byp_rst_n = 1'b1;
   endtask

   task automatic reset_dc;
      @(negedge clk);
      dc_rst_n = 1'b0;
      repeat (2) @(negedge clk);
      dc_rst_n = 1'b1;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_checks++;
      if (byp_if.out_valid !== 1'b0 || byp_if.out_data !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_byp_out: valid=%b data=%h, required valid=0 data=0000", byp_if.out_valid, byp_if.out_data);
      end
      n_checks++;
      if (byp_level !== 3'd0 || byp_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_byp_status: level=%0d ovf=%b, required level=0 ovf=0", byp_level, byp_ovf);
      end
      n_checks++;
      if (dc_if.out_valid !== 1'b0 || dc_if.out_data !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_dc_out: valid=%b data=%h, required valid=0 data=0000", dc_if.out_valid, dc_if.out_data);
      end
      n_checks++;
      if (dc_level !== 5'd0 || dc_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dc_status: level=%0d ovf=%b, required level=0 ovf=0", dc_level, dc_ovf);
      end
      @(negedge clk);
      byp_rst_n = 1'b1;
      dc_rst_n  = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Strobe rises before posedge 1; E is high after posedge 2, so out_valid
   // must first appear after posedge 5.
   task automatic test_bypass;
      @(negedge clk);
      byp_pcm     = 16'h1234;
      byp_pcm_clk = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (byp_if.out_valid !== 1'(k == 5)) begin
            n_fail++;
            $display("FAIL bypass_latency[%0d]: out_valid=%b, required %b", k, byp_if.out_valid, 1'(k == 5));
         end
      end
      n_checks++;
      if (byp_if.out_data !== 16'h1234 || byp_level !== 3'd1) begin
         n_fail++;
         $display("FAIL bypass_data: data=%h level=%0d, required data=1234 level=1", byp_if.out_data, byp_level);
      end
      repeat (5) @(negedge clk);
      byp_pcm_clk = 1'b0;
      repeat (3) @(negedge clk);
      byp_if.out_ready = 1'b1;
      @(negedge clk);
      byp_if.out_ready = 1'b0;
      n_checks++;
      if (byp_if.out_valid !== 1'b0 || byp_level !== 3'd0) begin
         n_fail++;
         $display("FAIL bypass_pop: valid=%b level=%0d, required valid=0 level=0", byp_if.out_valid, byp_level);
      end
   endtask

   task automatic test_dc_block;
      logic signed [15:0] exp_d [3];
      exp_d[0] = 16'sd1000;
      exp_d[1] = 16'sd937;
      exp_d[2] = 16'sd878;
      reset_dc();
      for (int i = 0; i < 3; i++) send_dc(16'd1000);
      n_checks++;
      if (u_dc.g_dc.acc_reg !== 40'sd225000 || dc_level !== 5'd3) begin
         n_fail++;
         $display("FAIL dc_acc: acc=%0d level=%0d, required acc=225000 level=3", u_dc.g_dc.acc_reg, dc_level);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (dc_if.out_valid !== 1'b1 || dc_if.out_data !== exp_d[i]) begin
            n_fail++;
            $display("FAIL dc_block[%0d]: valid=%b data=%0d, required valid=1 data=%0d", i, dc_if.out_valid, dc_if.out_data, exp_d[i]);
         end
         dc_if.out_ready = 1'b1;
         @(negedge clk);
         dc_if.out_ready = 1'b0;
      end
   endtask

   task automatic test_saturation;
      logic signed [15:0] exp_d [2];
      exp_d[0] = 16'sh8000;
      exp_d[1] = 16'sh7FFF;
      reset_dc();
      send_dc(16'h8000);
      send_dc(16'h7FFF);
      n_checks++;
      if (u_dc.g_dc.acc_reg !== 40'sd8912640) begin
         n_fail++;
         $display("FAIL sat_acc: acc=%0d, required 8912640", u_dc.g_dc.acc_reg);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (dc_if.out_valid !== 1'b1 || dc_if.out_data !== exp_d[i]) begin
            n_fail++;
            $display("FAIL saturation[%0d]: valid=%b data=%0d, required valid=1 data=%0d", i, dc_if.out_valid, dc_if.out_data, exp_d[i]);
         end
         dc_if.out_ready = 1'b1;
         @(negedge clk);
         dc_if.out_ready = 1'b0;
      end
   endtask

   task automatic test_overflow;
      reset_byp();
      for (int v = 1; v <= 5; v++) send_byp(16'(v), 0);
      n_checks++;
      if (byp_level !== 3'd4 || byp_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_set: level=%0d ovf=%b, required level=4 ovf=1", byp_level, byp_ovf);
      end
      // a clear landing in the same cycle as another drop must lose
      send_byp(16'd6, 1);
      n_checks++;
      if (byp_level !== 3'd4 || byp_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_clear_vs_drop: level=%0d ovf=%b, required level=4 ovf=1", byp_level, byp_ovf);
      end
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (byp_if.out_valid !== 1'b1 || byp_if.out_data !== 16'(i)) begin
            n_fail++;
            $display("FAIL overflow_drain[%0d]: valid=%b data=%0d, required valid=1 data=%0d", i, byp_if.out_valid, byp_if.out_data, i);
         end
         byp_if.out_ready = 1'b1;
         @(negedge clk);
         byp_if.out_ready = 1'b0;
      end
      n_checks++;
      if (byp_if.out_valid !== 1'b0 || byp_level !== 3'd0 || byp_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_drained: valid=%b level=%0d ovf=%b, required valid=0 level=0 ovf=1", byp_if.out_valid, byp_level, byp_ovf);
      end
      byp_clear = 1'b1;
      @(negedge clk);
      byp_clear = 1'b0;
      n_checks++;
      if (byp_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_clear: ovf=%b, required 0", byp_ovf);
      end
   endtask

   task automatic test_simul_full;
      reset_byp();
      for (int v = 10; v <= 13; v++) send_byp(16'(v), 0);
      n_checks++;
      if (byp_level !== 3'd4) begin
         n_fail++;
         $display("FAIL simul_fill: level=%0d, required 4", byp_level);
      end
      send_byp(16'd14, 2);
      n_checks++;
      if (byp_level !== 3'd4 || byp_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_rw_full: level=%0d ovf=%b, required level=4 ovf=0", byp_level, byp_ovf);
      end
      for (int i = 11; i <= 14; i++) begin
         @(negedge clk);
         n_checks++;
         if (byp_if.out_valid !== 1'b1 || byp_if.out_data !== 16'(i)) begin
            n_fail++;
            $display("FAIL simul_drain[%0d]: valid=%b data=%0d, required valid=1 data=%0d", i, byp_if.out_valid, byp_if.out_data, i);
         end
         byp_if.out_ready = 1'b1;
         @(negedge clk);
         byp_if.out_ready = 1'b0;
      end
      mon_q.delete();
      byp_if.out_ready = 1'b1;
      mon_en = 1'b1;
      for (int i = 0; i < 20; i++) send_byp(16'(100 + i), 0);
      repeat (4) @(negedge clk);
      mon_en = 1'b0;
      byp_if.out_ready = 1'b0;
      n_checks++;
      if (mon_q.size() != 20 || byp_level !== 3'd0) begin
         n_fail++;
         $display("FAIL wrap_count: received=%0d level=%0d, required received=20 level=0", mon_q.size(), byp_level);
      end
      for (int i = 0; i < 20 && i < mon_q.size(); i++) begin
         n_checks++;
         if (mon_q[i] !== 16'(100 + i)) begin
            n_fail++;
            $display("FAIL wrap_order[%0d]: data=%0d, required %0d", i, mon_q[i], 100 + i);
         end
      end
   endtask

   task automatic test_reset_mid;
      reset_byp();
      for (int v = 1; v <= 5; v++) send_byp(16'(v), 0);
      byp_if.out_ready = 1'b1;
      @(negedge clk);
      byp_if.out_ready = 1'b0;
      n_checks++;
      if (byp_level !== 3'd3 || byp_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_setup: level=%0d ovf=%b, required level=3 ovf=1", byp_level, byp_ovf);
      end
      // after the third negedge the sample sits in the filter stage
      byp_pcm     = 16'h7777;
      byp_pcm_clk = 1'b1;
      repeat (3) @(negedge clk);
      #1 byp_rst_n = 1'b0;
      #1;
      n_checks++;
      if (byp_if.out_valid !== 1'b0 || byp_level !== 3'd0 || byp_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_async: valid=%b level=%0d ovf=%b, required valid=0 level=0 ovf=0", byp_if.out_valid, byp_level, byp_ovf);
      end
      byp_pcm_clk = 1'b0;
      repeat (4) @(negedge clk);
      byp_rst_n = 1'b1;
      repeat (6) @(negedge clk);
      n_checks++;
      if (byp_if.out_valid !== 1'b0 || byp_level !== 3'd0) begin
         n_fail++;
         $display("FAIL midrst_no_partial: valid=%b level=%0d, required valid=0 level=0", byp_if.out_valid, byp_level);
      end
      send_byp(16'h5A5A, 0);
      n_checks++;
      if (byp_if.out_valid !== 1'b1 || byp_if.out_data !== 16'h5A5A || byp_level !== 3'd1) begin
         n_fail++;
         $display("FAIL midrst_byp_after: valid=%b data=%h level=%0d, required valid=1 data=5a5a level=1", byp_if.out_valid, byp_if.out_data, byp_level);
      end

      reset_dc();
      send_dc(16'd500);
      @(negedge clk);
      #1 dc_rst_n = 1'b0;
      #1;
      n_checks++;
      if (dc_if.out_valid !== 1'b0 || dc_level !== 5'd0) begin
         n_fail++;
         $display("FAIL midrst_dc_async: valid=%b level=%0d, required valid=0 level=0", dc_if.out_valid, dc_level);
      end
      @(negedge clk);
      dc_rst_n = 1'b1;
      send_dc(16'd1000);
      n_checks++;
      if (dc_if.out_valid !== 1'b1 || dc_if.out_data !== 16'sd1000 || dc_level !== 5'd1) begin
         n_fail++;
         $display("FAIL midrst_dc_after: valid=%b data=%0d level=%0d, required valid=1 data=1000 level=1", dc_if.out_valid, dc_if.out_data, dc_level);
      end
   endtask

   initial begin
      byp_rst_n        = 1'b0;
      byp_pcm_clk      = 1'b0;
      byp_pcm          = 16'h0000;
      byp_clear        = 1'b0;
      byp_if.out_ready = 1'b0;
      dc_rst_n         = 1'b0;
      dc_pcm_clk       = 1'b0;
      dc_pcm           = 16'h0000;
      dc_clear         = 1'b0;
      dc_if.out_ready  = 1'b0;

      test_reset();
      test_bypass();
      test_dc_block();
      test_saturation();
      test_overflow();
      test_simul_full();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pcm_sample_fifo.md
Name: pcm_sample_fifo

Overview:
- Consumes the decimated PCM stream (pcm, pcm_clk) produced in the pdm_clk domain and carries it into the system clock domain.
- Optionally removes DC offset with a first-order high-pass filter, then buffers samples in a FIFO.
- Presents samples to downstream logic (audio processing / host interface) through a valid/ready handshake.

Parameters:
- DEPTH, 16, FIFO depth in samples; power of 2, minimum 2.
- DC_SHIFT, 4, DC-blocker pole shift K in 1..8; 0 bypasses the filter (output = input).

Ports:
- clk  input  1  system clock; frequency ≥ 4× pcm_clk frequency.
- rst_n  input  1  asynchronous active-low reset.
- pcm_clk  input  1  sample strobe from pdm_clk domain, asynchronous to clk; pcm is stable from its rising edge for ≥ 8 clk cycles.
- pcm  input  16  signed PCM sample, pdm_clk domain.
- out_data  output  16  signed sample at FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: a sample was dropped because the FIFO was full.
- clear_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rst_n=0) clears everything immediately:
  - out_valid=0, out_data=0, level=0, overflow=0.
  - Sync flops=0, x_prev=0, acc=0, FIFO pointers=0.
- Synchronizer:
  - pcm_clk passes through a 2-flop synchronizer plus a third flop for edge detect.
  - edge pulse E = s2 & ~s3, one clk wide per pcm_clk rising edge.
  - A pcm_clk held high produces exactly one pulse.
  - Because s3 resets to 0, a pcm_clk already high at reset release produces one pulse.
- Capture: in cycle E, pcm is registered into x (pcm is multi-bit and is not synchronized; its stability window guarantees correctness).
- Filter, cycle E+1 (K = DC_SHIFT):
  - Bypass (K=0): y = x.
  - Otherwise, with acc a 40-bit signed accumulator:
    - acc_next = acc + ((x − x_prev) <<< 8) − (acc >>> K), using arithmetic shift.
    - y = saturate16(acc_next >>> 8), clamped to [−32768, 32767].
    - x_prev <= x; acc <= acc_next. The accumulator itself is never saturated.
  - Filter state updates only on captured samples.
- FIFO write, cycle E+2: y is written if not full.
- Full with no read in the same cycle: the sample is dropped, overflow <= 1, and FIFO contents are unchanged.
- out_valid timing: if the FIFO was empty, out_valid=1 from cycle E+3, with out_data = y.
- FIFO organisation and read:
  - Circular buffer, DEPTH entries; read/write pointers carry one extra wrap bit.
  - empty = (rptr == wptr); full = (rptr[MSB] != wptr[MSB]) & (low bits equal).
  - Read on out_valid & out_ready: rptr advances and out_data shows the next entry in the following cycle.
  - out_data holds its value while out_ready=0.
  - out_data is the registered head (first-word-fall-through); its value when empty is don't-care except after reset (0).
- Simultaneous read and write:
  - When full: the read frees a slot and the write is accepted; level stays DEPTH and overflow is unchanged.
  - When empty: the write lands and out_valid rises next cycle; the read is ignored because out_valid was 0.
- level: updated every cycle as +1 on write only, −1 on read only, 0 on both or neither.
- overflow:
  - Sticky until clear_overflow=1 (sampled on clk).
  - If clear_overflow and a new drop occur in the same cycle, overflow stays 1.
- Reset mid-stream: any in-flight sample in the capture or filter stage is discarded; no partial write.
- Pointer wrap: order is preserved across any number of wraps; there is no data loss unless full.

Test Plan:
- Bypass, DC_SHIFT=0:
  - Stimulus: pcm=16'h1234, pcm_clk rising edge.
  - Required: out_valid rises exactly 3 clk after the E pulse, out_data=16'h1234, level=1.
  - Then out_ready=1 for one cycle → out_valid=0, level=0.
- DC blocker, DC_SHIFT=4:
  - Stimulus: constant pcm=1000 for three samples.
  - Required outputs: 1000, 937, 878 (acc = 256000, 240000, 225000).
- Saturation, DC_SHIFT=4:
  - Stimulus: pcm=−32768, then 32767.
  - Required outputs: −32768, then 32767 (unclamped value 34815).
  - Internal acc after the second sample = 8912640.
- Overflow, DEPTH=4, out_ready=0:
  - Stimulus: 5 samples 1,2,3,4,5.
  - Required: level=4, overflow=1.
  - Drain → 1,2,3,4 in order, level=0, overflow still 1.
  - Pulse clear_overflow → overflow=0.
- Simultaneous read/write at full, DEPTH=4:
  - Stimulus: FIFO full, out_ready=1 in the write cycle.
  - Required: no overflow, level stays 4.
  - Then run 20 further samples with continuous reads to cover pointer wrap: output order equals input order.
- Async reset mid-stream:
  - Stimulus: drop rst_n between clk edges while level=3 and a sample is in the filter stage.
  - Required: out_valid=0 and level=0 immediately (no clk edge needed), overflow=0.
  - After release, the next sample's output equals its bypass or first-sample filter value (acc restarted from 0).
